// File: rtl/mul_div_seq_pkg.sv
// rtl/mul_div_seq_pkg.sv - shared types and ALU opcodes for the sequential multiply/divide unit
package mul_div_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/mul_div_seq_alu.sv
// rtl/mul_div_seq_alu.sv - shared add/subtract ALU with carry/borrow status
module mul_div_seq_alu
    import mul_div_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] y,
    output logic         carry
);

    logic         sub;
    logic [N-1:0] b_eff;
    logic [N:0]   sum;

    // One adder serves both ops: subtract is a + ~b + 1; carry reports borrow on subtract.
    assign sub   = (op == ALU_SUB);
    assign b_eff = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    assign y     = sum[N-1:0];
    assign carry = sub ? ~sum[N] : sum[N];

endmodule

// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - iterative shift-add multiplier and restoring divider
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_dbz
);

    localparam int CW = $clog2(N) + 1;

    state_e         state_q, state_d;
    op_e            op_q;
    logic [N-1:0]   hi_q, lo_q, m_q;
    logic           dbz_q;
    logic [CW-1:0]  cnt_q;
    logic           last;

    logic [N-1:0]   alu_a, alu_y;
    logic [2:0]     alu_op;
    logic           alu_c;

    logic [N-1:0]   rem_sh;
    logic           take;
    logic [N-1:0]   mul_hi;
    logic           mul_c;

    // hi/lo double as rem/quo during division.
    assign rem_sh = {hi_q[N-2:0], lo_q[N-1]};
    assign take   = hi_q[N-1] | ~alu_c;
    assign mul_hi = lo_q[0] ? alu_y : hi_q;
    assign mul_c  = lo_q[0] & alu_c;
    assign last   = (cnt_q == CW'(N - 1));

    mul_div_seq_alu #(.N(N)) u_alu (
        .a     (alu_a),
        .b     (m_q),
        .op    (alu_op),
        .y     (alu_y),
        .carry (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_op    = ALU_ADD;
        alu_a     = hi_q;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_op[1])       state_d = ST_MUL;
                    else if (req_b == '0) state_d = ST_DONE;
                    else                  state_d = ST_DIV;
                end
            end
            ST_MUL: begin
                if (last) state_d = ST_DONE;
            end
            ST_DIV: begin
                alu_op = ALU_SUB;
                alu_a  = rem_sh;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            dbz_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q  <= op_e'(req_op);
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                        if (!req_op[1]) begin
                            lo_q <= req_b;
                            hi_q <= '0;
                            m_q  <= req_a;
                        end else if (req_b == '0) begin
                            // Divide by zero: preload the defined results, no iteration.
                            dbz_q <= 1'b1;
                            lo_q  <= '1;
                            hi_q  <= req_a;
                            m_q   <= '0;
                        end else begin
                            lo_q <= req_a;
                            hi_q <= '0;
                            m_q  <= req_b;
                        end
                    end
                end
                ST_MUL: begin
                    cnt_q <= cnt_q + CW'(1);
                    hi_q  <= {mul_c, mul_hi[N-1:1]};
                    lo_q  <= {mul_hi[0], lo_q[N-1:1]};
                end
                ST_DIV: begin
                    cnt_q <= cnt_q + CW'(1);
                    hi_q  <= take ? alu_y : rem_sh;
                    lo_q  <= {lo_q[N-2:0], take};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_result = '0;
        if (state_q == ST_DONE) begin
            case (op_q)
                OP_MUL:   rsp_result = lo_q;
                OP_MULHU: rsp_result = hi_q;
                OP_DIVU:  rsp_result = lo_q;
                OP_REMU:  rsp_result = hi_q;
                default:  rsp_result = '0;
            endcase
        end
    end

    assign rsp_dbz = rsp_valid & dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// tb/tb_mul_div_seq.sv - self-checking bench for mul_div_seq against a behavioural model
module tb_mul_div_seq;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_dbz;

    int errors = 0;
    int checks = 0;

    mul_div_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_dbz    (rsp_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands, returns {dbz, result}.
    function automatic logic [32:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return {1'b0, p[31:0]};
            2'd1:    return {1'b0, p[63:32]};
            2'd2:    return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
        endcase
    endfunction

    // Transaction-level model: 0 idle, 1 computing, 2 holding a response.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_res   = '0;
    logic        m_dbz   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    {m_dbz, m_res} = ref_op(req_op, req_a, req_b);
                    if (m_dbz) m_phase = 2;
                    else begin
                        m_phase = 1;
                        m_left  = N;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 64'(req_ready), 64'(m_phase == 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
        if (m_phase == 2) begin
            chk("rsp_result", 64'(rsp_result), 64'(m_res));
            chk("rsp_dbz", 64'(rsp_dbz), 64'(m_dbz));
        end else begin
            chk("rsp_dbz_idle", 64'(rsp_dbz), 64'd0);
        end
        if (!rst_n) chk("rsp_result_rst", 64'(rsp_result), 64'd0);
    end

    task automatic wait_rsp(input logic [31:0] exp_r, input logic exp_d, input int exp_lat, input string nm);
        int cyc;
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, " result"}, 64'(rsp_result), 64'(exp_r));
        chk({nm, " dbz"}, 64'(rsp_dbz), 64'(exp_d));
        chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble the operand inputs to show they were latched.
        req_op    = 2'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic directed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_r, input logic exp_d, input int exp_lat, input string nm);
        issue(op, a, b);
        wait_rsp(exp_r, exp_d, exp_lat, nm);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_result", 64'(rsp_result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("model mulhu", 64'(ref_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), {31'd0, 1'b0, 32'hFFFF_FFFE});
        chk("model remu", 64'(ref_op(2'd3, 32'd100, 32'd7)), 64'd2);

        directed(2'd0, 32'd7, 32'd6, 32'd42, 1'b0, N + 1, "mul 7x6");
        directed(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, N + 1, "mulhu max");
        directed(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, N + 1, "mul max");
        directed(2'd2, 32'd100, 32'd7, 32'd14, 1'b0, N + 1, "divu 100/7");
        directed(2'd3, 32'd100, 32'd7, 32'd2, 1'b0, N + 1, "remu 100/7");
        directed(2'd2, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, N + 1, "divu msb/1");
        directed(2'd2, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, "divu 55/0");
        directed(2'd3, 32'd55, 32'd0, 32'd55, 1'b1, 1, "remu 55/0");

        // Backpressure, with a queued request held on req_valid.
        issue(2'd0, 32'h1234, 32'h10);
        wait_rsp(32'h12340, 1'b0, N + 1, "bp mul");
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'd2;
        req_b     = 32'd9;
        for (int i = 0; i < 5; i++) begin
            chk("bp stable", 64'(rsp_result), 64'h12340);
            chk("bp req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp back to idle", 64'(req_ready), 64'd1);
        chk("bp valid dropped", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp accepted", 64'(req_ready), 64'd0);
        wait_rsp(32'd18, 1'b0, N + 1, "bp mul 2x9");
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset at iteration 10 of a divide.
        issue(2'd2, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort req_ready", 64'(req_ready), 64'd1);
        chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort rsp_dbz", 64'(rsp_dbz), 64'd0);
        chk("abort rsp_result", 64'(rsp_result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (N + 8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort no response", 64'(seen), 64'd0);
        directed(2'd0, 32'd3, 32'd5, 32'd15, 1'b0, N + 1, "mul 3x5");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 2) != 0);
            req_op    = 2'($urandom);
            req_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0:       req_b = '0;
                1, 2:    req_b = 32'($urandom_range(1, 20));
                default: req_b = $urandom;
            endcase
            rsp_ready = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("drain idle", 64'(req_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
